// File: rtl/pcie_s10_msi_arb_pkg.sv
// pcie_s10_msi_arb_pkg: shared helper for mapping a source index onto the granted MSI vector range.
package pcie_s10_msi_arb_pkg;

    function automatic logic [4:0] msi_vec(input logic [4:0] idx, input logic [2:0] m);
        logic [5:0] span;
        span = (6'd1 << m) - 6'd1;
        return idx & span[4:0];
    endfunction

endpackage

// File: rtl/pcie_msi_rr_sel.sv
// pcie_msi_rr_sel: combinational round-robin selector, rotate by rr_ptr, priority-encode, un-rotate.
module pcie_msi_rr_sel #(
    parameter int IRQ_COUNT = 32,
    parameter int IW = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1
) (
    input  logic [IRQ_COUNT-1:0] request,
    input  logic [IW-1:0]        rr_ptr,
    output logic                 grant_valid,
    output logic [IW-1:0]        grant_index
);

    localparam logic [IW:0] CNT = (IW + 1)'(IRQ_COUNT);

    logic [IRQ_COUNT-1:0] rot;
    logic [IW-1:0]        pos;
    logic [IW:0]          sum;

    always_comb begin
        rot = IRQ_COUNT'({request, request} >> rr_ptr);
        pos = '0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) pos = rot[i] ? IW'(i) : pos;
        sum = {1'b0, pos} + {1'b0, rr_ptr};
        grant_index = (sum >= CNT) ? IW'(sum - CNT) : sum[IW-1:0];
        grant_valid = |request;
    end

endmodule

// File: rtl/pcie_s10_msi_arb.sv
// pcie_s10_msi_arb: round-robin MSI arbiter driving the Stratix 10 app_msi request/ack handshake.
module pcie_s10_msi_arb
    import pcie_s10_msi_arb_pkg::*;
#(
    parameter int          IRQ_COUNT       = 32,
    parameter int          IRQ_INDEX_WIDTH = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1,
    parameter logic [2:0]  MSI_TC          = 3'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_COUNT-1:0] irq,
    input  logic [IRQ_COUNT-1:0] irq_mask,
    input  logic                 msi_enable,
    input  logic [2:0]           msi_mme,
    input  logic [1:0]           msi_func_num,
    output logic                 app_msi_req,
    input  logic                 app_msi_ack,
    output logic [2:0]           app_msi_tc,
    output logic [4:0]           app_msi_num,
    output logic [1:0]           app_msi_func_num,
    output logic [IRQ_COUNT-1:0] irq_pending,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    localparam logic [2:0]                 MME_CAP = 3'd5;
    localparam logic [IRQ_INDEX_WIDTH-1:0] LAST    = IRQ_INDEX_WIDTH'(IRQ_COUNT - 1);

    state_t                      state_q, state_d;
    logic [IRQ_COUNT-1:0]        pend_q, pend_d, clr;
    logic [IRQ_INDEX_WIDTH-1:0]  ptr_q, ptr_d, grant_index;
    logic [4:0]                  num_q, num_d;
    logic [1:0]                  func_q, func_d;
    logic [2:0]                  mme_cap;
    logic                        grant_valid;

    pcie_msi_rr_sel #(
        .IRQ_COUNT (IRQ_COUNT),
        .IW        (IRQ_INDEX_WIDTH)
    ) u_sel (
        .request     (pend_q & ~irq_mask),
        .rr_ptr      (ptr_q),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        num_d   = num_q;
        func_d  = func_q;
        clr     = '0;
        mme_cap = (msi_mme > MME_CAP) ? MME_CAP : msi_mme;
        case (state_q)
            IDLE: if (msi_enable && grant_valid) begin
                state_d          = REQ;
                num_d            = msi_vec(5'(grant_index), mme_cap);
                func_d           = msi_func_num;
                clr[grant_index] = 1'b1;
                ptr_d            = (grant_index == LAST) ? '0 : grant_index + 1'b1;
            end
            REQ:     state_d = app_msi_ack ? GAP : REQ;
            default: state_d = IDLE;
        endcase
        // a pulse landing on the selection edge re-arms the bit
        pend_d = (pend_q & ~clr) | irq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
            num_q   <= '0;
            func_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            num_q   <= num_d;
            func_q  <= func_d;
        end
    end

    assign app_msi_req      = (state_q == REQ);
    assign busy             = (state_q != IDLE);
    assign app_msi_tc       = MSI_TC;
    assign app_msi_num      = num_q;
    assign app_msi_func_num = func_q;
    assign irq_pending      = pend_q;

endmodule

// File: tb/tb_pcie_s10_msi_arb.sv
// tb_pcie_s10_msi_arb: directed bench with a cycle-level scoreboard model of the MSI arbiter.
module tb_pcie_s10_msi_arb;

    localparam int N = 64;
    localparam logic [2:0] TC = 3'd5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] irq = '0;
    logic [N-1:0] irq_mask = '0;
    logic         msi_enable = 1'b1;
    logic [2:0]   msi_mme = 3'd5;
    logic [1:0]   msi_func_num = 2'd2;
    logic         app_msi_ack = 1'b0;
    logic         app_msi_req;
    logic [2:0]   app_msi_tc;
    logic [4:0]   app_msi_num;
    logic [1:0]   app_msi_func_num;
    logic [N-1:0] irq_pending;
    logic         busy;

    int total = 0;
    int bad = 0;

    pcie_s10_msi_arb #(.IRQ_COUNT(N), .MSI_TC(TC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .irq              (irq),
        .irq_mask         (irq_mask),
        .msi_enable       (msi_enable),
        .msi_mme          (msi_mme),
        .msi_func_num     (msi_func_num),
        .app_msi_req      (app_msi_req),
        .app_msi_ack      (app_msi_ack),
        .app_msi_tc       (app_msi_tc),
        .app_msi_num      (app_msi_num),
        .app_msi_func_num (app_msi_func_num),
        .irq_pending      (irq_pending),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 requesting, 2 gap; pending as a plain bit set with a round-robin pointer.
    int           m_phase, m_ptr, sel;
    logic [N-1:0] m_pend;
    logic [4:0]   m_num;
    logic [1:0]   m_func;

    function automatic int pick(input logic [N-1:0] e, input int p);
        for (int k = 0; k < N; k++) if (e[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [4:0] vec(input int s, input logic [2:0] mme);
        int cap;
        cap = (mme > 3'd5) ? 5 : int'(mme);
        return 5'(s % (1 << cap));
    endfunction

    always_comb sel = (m_phase == 0 && msi_enable) ? pick(m_pend & ~irq_mask, m_ptr) : -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_ptr   <= 0;
            m_pend  <= '0;
            m_num   <= '0;
            m_func  <= '0;
        end else if (sel >= 0) begin
            m_phase <= 1;
            m_num   <= vec(sel, msi_mme);
            m_func  <= msi_func_num;
            m_ptr   <= (sel + 1) % N;
            m_pend  <= (m_pend & ~(N'(1) << sel)) | irq;
        end else begin
            m_pend  <= m_pend | irq;
            m_phase <= (m_phase == 1 && app_msi_ack) ? 2 : (m_phase == 2) ? 0 : m_phase;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_req", 64'(app_msi_req), 64'(m_phase == 1));
            chk("m_busy", 64'(busy), 64'(m_phase != 0));
            chk("m_pend", 64'(irq_pending), 64'(m_pend));
            chk("m_tc", 64'(app_msi_tc), 64'(TC));
            if (m_phase == 1) begin
                chk("m_num", 64'(app_msi_num), 64'(m_num));
                chk("m_func", 64'(app_msi_func_num), 64'(m_func));
            end
        end
    end

    task automatic pulse(input logic [N-1:0] v);
        irq = v;
        @(negedge clk);
        irq = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (!app_msi_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_req"}, 64'(app_msi_req), 64'd1);
    endtask

    task automatic do_ack();
        app_msi_ack = 1'b1;
        @(negedge clk);
        app_msi_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic serve(input string nm, input logic [4:0] exp);
        wait_req(nm);
        chk(nm, 64'(app_msi_num), 64'(exp));
        do_ack();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N-1:0] bit_of(input int i);
        return N'(1) << i;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", 64'(app_msi_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pend", 64'(irq_pending), 64'd0);
        chk("rst_num", 64'(app_msi_num), 64'd0);
        chk("rst_func", 64'(app_msi_func_num), 64'd0);
        chk("rst_tc", 64'(app_msi_tc), 64'(TC));
        idle(2);
        rst_n = 1'b1;

        // single source, cycle-exact latency
        pulse(bit_of(3));
        chk("t1_pend", 64'(irq_pending[3]), 64'd1);
        chk("t1_noreq", 64'(app_msi_req), 64'd0);
        @(negedge clk);
        chk("t1_req", 64'(app_msi_req), 64'd1);
        chk("t1_num", 64'(app_msi_num), 64'd3);
        chk("t1_func", 64'(app_msi_func_num), 64'd2);
        chk("t1_clr", 64'(irq_pending), 64'd0);
        idle(3);
        app_msi_ack = 1'b1;
        @(negedge clk);
        app_msi_ack = 1'b0;
        chk("t1_gap_req", 64'(app_msi_req), 64'd0);
        chk("t1_gap_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_idle", 64'(busy), 64'd0);

        // round robin from pointer 0, then wrap
        do_reset();
        pulse(bit_of(1) | bit_of(4) | bit_of(30));
        serve("rr0", 5'd1);
        serve("rr1", 5'd4);
        serve("rr2", 5'd30);
        pulse(bit_of(1) | bit_of(2));
        serve("rr3", 5'd1);
        serve("rr4", 5'd2);
        pulse(bit_of(63) | bit_of(0));
        serve("wrap0", 5'd31);
        serve("wrap1", 5'd0);

        // vector truncation
        msi_mme = 3'd2;
        msi_func_num = 2'd1;
        pulse(bit_of(13));
        wait_req("mme2");
        chk("mme2", 64'(app_msi_num), 64'd1);
        chk("mme2_func", 64'(app_msi_func_num), 64'd1);
        do_ack();
        msi_mme = 3'd7;
        pulse(bit_of(37));
        serve("mme7", 5'd5);
        msi_mme = 3'd5;

        // coalescing while stalled
        pulse(bit_of(7));
        wait_req("coal");
        pulse(bit_of(7));
        idle(1);
        pulse(bit_of(7));
        idle(1);
        pulse(bit_of(7));
        chk("coal_pend", 64'(irq_pending[7]), 64'd1);
        chk("coal_hold", 64'(app_msi_req), 64'd1);
        do_ack();
        serve("coal2", 5'd7);
        idle(5);
        chk("coal_once", 64'(app_msi_req), 64'd0);

        // set wins over the selection clear
        irq = bit_of(9);
        idle(2);
        irq = '0;
        serve("sw0", 5'd9);
        serve("sw1", 5'd9);

        // enable gating
        msi_enable = 1'b0;
        pulse(bit_of(0));
        idle(4);
        chk("en_noreq", 64'(app_msi_req), 64'd0);
        chk("en_pend", 64'(irq_pending[0]), 64'd1);
        msi_enable = 1'b1;
        serve("en", 5'd0);

        // mask gating
        irq_mask = bit_of(5);
        pulse(bit_of(5));
        idle(4);
        chk("mask_noreq", 64'(app_msi_req), 64'd0);
        chk("mask_pend", 64'(irq_pending[5]), 64'd1);
        irq_mask = '0;
        serve("mask", 5'd5);

        // enable drops during request
        pulse(bit_of(10));
        wait_req("endrop");
        msi_enable = 1'b0;
        pulse(bit_of(11));
        idle(3);
        chk("endrop_hold", 64'(app_msi_req), 64'd1);
        chk("endrop_num", 64'(app_msi_num), 64'd10);
        do_ack();
        idle(3);
        chk("endrop_none", 64'(app_msi_req), 64'd0);
        chk("endrop_pend", 64'(irq_pending[11]), 64'd1);
        msi_enable = 1'b1;
        serve("endrop2", 5'd11);

        // mask after selection
        pulse(bit_of(12));
        wait_req("lmask");
        irq_mask = bit_of(12);
        idle(2);
        chk("lmask_hold", 64'(app_msi_req), 64'd1);
        do_ack();
        irq_mask = '0;
        idle(3);
        chk("lmask_done", 64'(busy), 64'd0);

        // stray ack while idle
        app_msi_ack = 1'b1;
        idle(3);
        app_msi_ack = 1'b0;
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_req", 64'(app_msi_req), 64'd0);

        // reset mid-handshake
        pulse(bit_of(20));
        wait_req("rst");
        pulse(bit_of(21));
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_req", 64'(app_msi_req), 64'd0);
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_pend", 64'(irq_pending), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        app_msi_ack = 1'b1;
        @(negedge clk);
        app_msi_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 64'(app_msi_req), 64'd0);
        chk("late_ack_busy", 64'(busy), 64'd0);
        pulse(bit_of(3));
        serve("post", 5'd3);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
